// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART blocks.
// The RX block will reuse the same state encoding and parity constants.
package uart_pkg;

    localparam int unsigned MIN_DATA_BITS     = 5;
    localparam int unsigned DEF_MAX_DATA_BITS = 9;
    localparam int unsigned DEF_DIV_W         = 16;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Ready/valid payload handshake between the register block and the UART TX.
interface uart_tx_cfg_if #(
    parameter int unsigned MAX_DATA_BITS = uart_pkg::DEF_MAX_DATA_BITS
);

    logic [MAX_DATA_BITS-1:0] tx_data;
    logic                     tx_valid;
    logic                     tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; bit_end marks the last cycle of a bit.
// Shared between the TX and the future RX block.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] reload,
    output logic             bit_end
);

    logic [DIV_W-1:0] count_q;

    assign bit_end = (count_q == '0);

    // Reload at every bit boundary so consecutive bits need no restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!en) begin
            count_q <= '0;
        end else if (restart || bit_end) begin
            count_q <= reload;
        end else begin
            count_q <= count_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-9 data bits, parity, 1/2 stop bits)
// with a one-entry holding register for back-to-back frames.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = DEF_MAX_DATA_BITS,
    parameter int unsigned DIV_W         = DEF_DIV_W,
    parameter int unsigned CLK_FREQ      = 1000000,
    parameter int unsigned BAUD_RATE     = 115200
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_cfg_if.slave     bus,
    input  logic [3:0]       data_bits,
    input  logic [2:0]       parity_mode,
    input  logic             stop2,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tx,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int unsigned CNT_W = 4;

    if (BAUD_RATE == 0 || CLK_FREQ < BAUD_RATE) begin : g_bad_rate
        $error("uart_tx_cfg: CLK_FREQ must be at least BAUD_RATE");
    end

    tx_state_e state_q, state_d;

    logic [CNT_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         nbits_q, nbits_d;
    logic [CNT_W-1:0]         db_c;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic [MAX_DATA_BITS-1:0] hold_data_q;
    logic [MAX_DATA_BITS-1:0] src_c, mask_c, masked_c;
    logic [2:0]               pm_q, pm_d, pm_c;
    logic [DIV_W-1:0]         period_q, period_d, period_c, reload_c;
    logic                     stop2_q, stop2_d;
    logic                     stop_sec_q, stop_sec_d;
    logic                     par_bit_q, par_bit_d, par_bit_c;
    logic                     hold_empty_q;
    logic                     load_c, done_c, tx_d;
    logic                     bit_end;
    logic                     accept_c, hold_wr_c, drain_c, baud_en_c;

    // Configuration decode and payload preparation for the frame being loaded.
    always_comb begin
        db_c = data_bits;
        if (data_bits < CNT_W'(MIN_DATA_BITS)) begin
            db_c = CNT_W'(MIN_DATA_BITS);
        end else if (data_bits > CNT_W'(MAX_DATA_BITS)) begin
            db_c = CNT_W'(MAX_DATA_BITS);
        end

        pm_c     = (parity_mode > PAR_SPACE) ? PAR_NONE : parity_mode;
        period_c = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
        src_c    = hold_empty_q ? bus.tx_data : hold_data_q;

        for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
            mask_c[i] = (CNT_W'(i) < db_c);
        end
        // Unsent bits are zeroed so the parity covers exactly the sent bits.
        masked_c = src_c & mask_c;

        case (pm_c)
            PAR_EVEN: par_bit_c = ^masked_c;
            PAR_ODD:  par_bit_c = ~^masked_c;
            PAR_MARK: par_bit_c = 1'b1;
            default:  par_bit_c = 1'b0;
        endcase
    end

    // Next-state, frame load and serial bit selection.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        nbits_d    = nbits_q;
        shift_d    = shift_q;
        pm_d       = pm_q;
        period_d   = period_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        par_bit_d  = par_bit_q;
        load_c     = 1'b0;
        done_c     = 1'b0;
        tx_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (!hold_empty_q || bus.tx_valid) begin
                    load_c = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == nbits_q - CNT_W'(1)) begin
                        state_d    = (pm_q == PAR_NONE) ? STOP : PARITY;
                        stop_sec_d = 1'b0;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_sec_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        done_c = 1'b1;
                        if (!hold_empty_q) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            state_d    = START;
            idx_d      = '0;
            nbits_d    = db_c;
            shift_d    = masked_c;
            pm_d       = pm_c;
            period_d   = period_c;
            stop2_d    = stop2;
            stop_sec_d = 1'b0;
            par_bit_d  = par_bit_c;
        end

        // tx is decoded from the next state so the registered line tracks the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    // Holding register only captures while a frame is in flight; idle accepts bypass it.
    always_comb begin
        accept_c  = bus.tx_valid && hold_empty_q;
        hold_wr_c = accept_c && (state_q != IDLE);
        drain_c   = load_c && !hold_empty_q;
        baud_en_c = (state_d != IDLE);
        reload_c  = load_c ? period_c : period_q;
    end

    assign bus.tx_ready = hold_empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_q  <= '0;
            hold_empty_q <= 1'b1;
        end else if (hold_wr_c) begin
            hold_data_q  <= bus.tx_data;
            hold_empty_q <= 1'b0;
        end else if (drain_c) begin
            hold_empty_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            nbits_q    <= '0;
            shift_q    <= '0;
            pm_q       <= PAR_NONE;
            period_q   <= '0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            pm_q       <= pm_d;
            period_q   <= period_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            par_bit_q  <= par_bit_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_d;
            tx_busy    <= (state_d != IDLE);
            frame_done <= done_c;
        end
    end

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (baud_en_c),
        .restart (load_c),
        .reload  (reload_c),
        .bit_end (bit_end)
    );

endmodule
